// File: rtl/ks10_bus_pkg.sv
// Shared KS10 backplane definitions: flag bit positions in the address word,
// address field bounds and the memory responder state encoding.
package ks10_bus_pkg;

    // Flag bits in the 36-bit [0:35] address word
    localparam int F_READ   = 3;
    localparam int F_WRTEST = 4;
    localparam int F_WRITE  = 5;
    localparam int F_IO     = 8;

    // Word address field
    localparam int ADDR_LO  = 16;
    localparam int ADDR_HI  = 35;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WRITEBACK,
        ACK,
        HOLD,
        REJECT
    } state_t;

endpackage

// File: rtl/ks10_mem_sram.sv
// Inferred AWx36 single-port synchronous RAM, one-cycle read latency.
// Ports: clk, we (write enable), addr, din (write data), dout (read data).
module ks10_mem_sram #(
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [35:0]   din,
    output logic [35:0]   dout
);

    logic [35:0] mem [2**AW];

    // Read-first: dout shows the old word in a write cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ks10_mem_responder.sv
// KS10 backplane memory responder: services arbiter requests against a
// synchronous SRAM; unserviceable requests get no ACK and a one-cycle nxmO.
// Ports: clk, rstN; bus side busREQI/busACKO/busADDRI/busDATAI/busDATAO;
// SRAM side sramADDR/sramWE/sramDOUT/sramDIN; nxmO reject pulse.
module ks10_mem_responder
    import ks10_bus_pkg::*;
#(
    parameter int          MEM_AW      = 20,
    parameter int unsigned MEM_SIZE    = 20'h40000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              busREQI,
    output logic              busACKO,
    input  logic [0:35]       busADDRI,
    input  logic [0:35]       busDATAI,
    output logic [0:35]       busDATAO,
    output logic [MEM_AW-1:0] sramADDR,
    output logic              sramWE,
    output logic [35:0]       sramDOUT,
    input  logic [35:0]       sramDIN,
    output logic              nxmO
);

    state_t            state;
    logic [3:0]        cnt;
    logic              op_rd;
    logic              op_wr;
    logic              drop;
    logic [35:0]       rdat;

    logic [19:0]       afield;
    logic [MEM_AW-1:0] addr;
    logic              rd;
    logic              wr;
    logic              reject;
    logic              unused_bits;

    assign afield = busADDRI[ADDR_LO:ADDR_HI];
    assign addr   = afield[MEM_AW-1:0];
    assign rd     = busADDRI[F_READ] | busADDRI[F_WRTEST];
    assign wr     = busADDRI[F_WRITE];
    assign reject = busADDRI[F_IO] | ~(rd | wr)
                  | (32'(addr) >= MEM_SIZE);

    assign unused_bits = ^{busADDRI[0:2], busADDRI[6:7],
                           busADDRI[9:15], afield};

    assign busACKO = (state == ACK);

    // Plain reads return the SRAM output directly: it is valid in the ACK
    // cycle because the address is held and nothing writes it. RMW has
    // already overwritten the word, so it returns the copy taken in
    // WRITEBACK (the read-before-write value).
    always_comb begin
        busDATAO = '0;
        if (state == ACK && op_rd) begin
            busDATAO = op_wr ? rdat : sramDIN;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            cnt      <= '0;
            op_rd    <= 1'b0;
            op_wr    <= 1'b0;
            drop     <= 1'b0;
            rdat     <= '0;
            sramADDR <= '0;
            sramWE   <= 1'b0;
            sramDOUT <= '0;
            nxmO     <= 1'b0;
        end else begin
            sramWE <= 1'b0;
            nxmO   <= 1'b0;
            case (state)
                IDLE: begin
                    if (busREQI) begin
                        if (reject) begin
                            state <= REJECT;
                            nxmO  <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            sramADDR <= addr;
                            sramDOUT <= busDATAI;
                            op_rd    <= rd;
                            op_wr    <= wr;
                            drop     <= 1'b0;
                            cnt      <= 4'(WAIT_STATES);
                            sramWE   <= wr & ~rd;
                        end
                    end
                end
                ACCESS: begin
                    if (!busREQI) begin
                        drop <= 1'b1;
                    end
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (op_rd && op_wr) begin
                        state  <= WRITEBACK;
                        sramWE <= 1'b1;
                    end else if (drop || !busREQI) begin
                        state <= IDLE;
                    end else begin
                        state <= ACK;
                    end
                end
                WRITEBACK: begin
                    rdat  <= sramDIN;
                    state <= (drop || !busREQI) ? IDLE : ACK;
                end
                ACK: begin
                    state <= HOLD;
                end
                HOLD, REJECT: begin
                    if (!busREQI) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks10_mem_responder.sv
// Self-checking bench for ks10_mem_responder: three instances with
// WAIT_STATES 0, 2 and 3, each on its own SRAM, against a word-level model.
module tb_ks10_mem_responder;

    localparam int unsigned MSIZE = 20'h40000;

    logic        clk;
    logic        rstN;
    logic        req  [3];
    logic [0:35] addr [3];
    logic [0:35] wdat [3];
    logic        ack  [3];
    logic [0:35] dato [3];
    logic        nxm  [3];
    logic [19:0] sa   [3];
    logic        swe  [3];
    logic [35:0] sdo  [3];
    logic [35:0] sdi  [3];

    int pass_cnt = 0;
    int total    = 0;

    logic [35:0] mdl [int];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ks10_mem_responder #(
            .MEM_AW     (20),
            .MEM_SIZE   (MSIZE),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk     (clk),
            .rstN    (rstN),
            .busREQI (req[g]),
            .busACKO (ack[g]),
            .busADDRI(addr[g]),
            .busDATAI(wdat[g]),
            .busDATAO(dato[g]),
            .sramADDR(sa[g]),
            .sramWE  (swe[g]),
            .sramDOUT(sdo[g]),
            .sramDIN (sdi[g]),
            .nxmO    (nxm[g])
        );
        ks10_mem_sram #(.AW(20)) u_ram (
            .clk (clk),
            .we  (swe[g]),
            .addr(sa[g]),
            .din (sdo[g]),
            .dout(sdi[g])
        );
    end

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ws(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic int key(input int k, input logic [19:0] a);
        return (k << 20) | int'(a);
    endfunction

    function automatic logic [0:35] mk(input bit r, input bit t,
                                       input bit w, input bit io,
                                       input logic [19:0] a);
        logic [0:35] v;
        v = '0;
        v[3] = r;
        v[4] = t;
        v[5] = w;
        v[8] = io;
        v[16:35] = a;
        return v;
    endfunction

    // Holds a request for 'hold' cycles after T0, then low for 'gap'
    // cycles, observing each cycle at the falling edge.
    task automatic run_req(input int k, input logic [0:35] fl,
                           input logic [35:0] d, input int hold,
                           input int gap, output int ackn,
                           output int ack1, output logic [35:0] adat,
                           output int nxmn, output int wen,
                           output int leak);
        ackn = 0;
        ack1 = -1;
        adat = '0;
        nxmn = 0;
        wen  = 0;
        leak = 0;
        addr[k] = fl;
        wdat[k] = d;
        req[k]  = 1'b1;
        for (int n = 1; n <= hold + gap; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[k]) begin
                ackn++;
                if (ack1 < 0) begin
                    ack1 = n;
                    adat = dato[k];
                end
            end else if (dato[k] !== '0) begin
                leak++;
            end
            if (nxm[k]) nxmn++;
            if (swe[k]) wen++;
            if (n == hold) req[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            total++; if (ack[k] !== 1'b0) $display("FAIL reset_ack[%0d]: got %b want 0", k, ack[k]); else pass_cnt++;
            total++; if (dato[k] !== '0) $display("FAIL reset_data[%0d]: got %o want 0", k, dato[k]); else pass_cnt++;
            total++; if (sa[k] !== '0) $display("FAIL reset_sramaddr[%0d]: got %h want 0", k, sa[k]); else pass_cnt++;
            total++; if (swe[k] !== 1'b0) $display("FAIL reset_sramwe[%0d]: got %b want 0", k, swe[k]); else pass_cnt++;
            total++; if (sdo[k] !== '0) $display("FAIL reset_sramdout[%0d]: got %o want 0", k, sdo[k]); else pass_cnt++;
            total++; if (nxm[k] !== 1'b0) $display("FAIL reset_nxm[%0d]: got %b want 0", k, nxm[k]); else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        int an, a1, nn, wn, lk;
        logic [35:0] ad;
        run_req(0, mk(0, 0, 1, 0, 20'o1000), 36'o123456_654321, 3, 2,
                an, a1, ad, nn, wn, lk);
        mdl[key(0, 20'o1000)] = 36'o123456_654321;
        total++; if (a1 !== 2) $display("FAIL wr_ack_cycle: got %0d want 2", a1); else pass_cnt++;
        total++; if (ad !== 36'o0) $display("FAIL wr_ack_data: got %o want 0", ad); else pass_cnt++;
        total++; if (wn !== 1) $display("FAIL wr_sram_writes: got %0d want 1", wn); else pass_cnt++;
        run_req(0, mk(1, 0, 0, 0, 20'o1000), '0, 3, 2,
                an, a1, ad, nn, wn, lk);
        total++; if (a1 !== 2) $display("FAIL rd_ack_cycle: got %0d want 2", a1); else pass_cnt++;
        total++; if (ad !== 36'o123456_654321) $display("FAIL rd_data: got %o want %o", ad, 36'o123456_654321); else pass_cnt++;
        total++; if (lk !== 0) $display("FAIL rd_data_leak: got %0d want 0", lk); else pass_cnt++;
    endtask

    task automatic test_rmw();
        int an, a1, nn, wn, lk;
        logic [35:0] ad;
        run_req(1, mk(0, 0, 1, 0, 20'o2500), 36'o1, 5, 2,
                an, a1, ad, nn, wn, lk);
        mdl[key(1, 20'o2500)] = 36'o1;
        total++; if (a1 !== 4) $display("FAIL rmw_pre_write_ack: got %0d want 4", a1); else pass_cnt++;
        run_req(1, mk(1, 0, 1, 0, 20'o2500), 36'o777, 6, 2,
                an, a1, ad, nn, wn, lk);
        mdl[key(1, 20'o2500)] = 36'o777;
        total++; if (a1 !== 5) $display("FAIL rmw_ack_cycle: got %0d want 5", a1); else pass_cnt++;
        total++; if (ad !== 36'o1) $display("FAIL rmw_old_data: got %o want 1", ad); else pass_cnt++;
        total++; if (an !== 1) $display("FAIL rmw_ack_count: got %0d want 1", an); else pass_cnt++;
        total++; if (wn !== 1) $display("FAIL rmw_writeback: got %0d want 1", wn); else pass_cnt++;
        run_req(1, mk(1, 0, 0, 0, 20'o2500), '0, 5, 2,
                an, a1, ad, nn, wn, lk);
        total++; if (ad !== 36'o777) $display("FAIL rmw_new_data: got %o want 777", ad); else pass_cnt++;
    endtask

    task automatic test_reject();
        int an, a1, nn, wn, lk;
        logic [35:0] ad;
        logic [0:35] fl [3];
        fl[0] = mk(1, 0, 0, 1, 20'o1000);
        fl[1] = mk(1, 0, 0, 0, 20'h40000);
        fl[2] = mk(0, 0, 0, 0, 20'o1000);
        for (int i = 0; i < 3; i++) begin
            run_req(0, fl[i], 36'o55, 20, 2, an, a1, ad, nn, wn, lk);
            total++; if (an !== 0) $display("FAIL reject%0d_ack: got %0d want 0", i, an); else pass_cnt++;
            total++; if (nn !== 1) $display("FAIL reject%0d_nxm_pulses: got %0d want 1", i, nn); else pass_cnt++;
            total++; if (wn !== 0) $display("FAIL reject%0d_sram_we: got %0d want 0", i, wn); else pass_cnt++;
            run_req(0, mk(1, 0, 0, 0, 20'o1000), '0, 3, 2,
                    an, a1, ad, nn, wn, lk);
            total++; if (a1 !== 2 || ad !== mdl[key(0, 20'o1000)]) $display("FAIL reject%0d_recover: got cycle %0d data %o want 2 %o", i, a1, ad, mdl[key(0, 20'o1000)]); else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int an, a1, nn, wn, lk;
        logic [35:0] ad;
        run_req(0, mk(0, 0, 1, 0, 20'o1234), 36'o42, 12, 1,
                an, a1, ad, nn, wn, lk);
        mdl[key(0, 20'o1234)] = 36'o42;
        total++; if (an !== 1) $display("FAIL hold_ack_count: got %0d want 1", an); else pass_cnt++;
        total++; if (wn !== 1) $display("FAIL hold_sram_access: got %0d want 1", wn); else pass_cnt++;
        run_req(0, mk(1, 0, 0, 0, 20'o1234), '0, 3, 2,
                an, a1, ad, nn, wn, lk);
        total++; if (a1 !== 2 || ad !== 36'o42) $display("FAIL hold_second_req: got cycle %0d data %o want 2 42", a1, ad); else pass_cnt++;
    endtask

    task automatic test_drop();
        int an, a1, nn, wn, lk;
        logic [35:0] ad;
        run_req(2, mk(0, 0, 1, 0, 20'o3000), 36'o111, 5, 2,
                an, a1, ad, nn, wn, lk);
        run_req(2, mk(0, 0, 1, 0, 20'o3000), 36'o765432_101234, 1, 6,
                an, a1, ad, nn, wn, lk);
        mdl[key(2, 20'o3000)] = 36'o765432_101234;
        total++; if (an !== 0) $display("FAIL drop_ack: got %0d want 0", an); else pass_cnt++;
        total++; if (wn !== 1) $display("FAIL drop_sram_write: got %0d want 1", wn); else pass_cnt++;
        run_req(2, mk(1, 0, 0, 0, 20'o3000), '0, 6, 2,
                an, a1, ad, nn, wn, lk);
        total++; if (a1 !== 5) $display("FAIL drop_read_ack: got %0d want 5", a1); else pass_cnt++;
        total++; if (ad !== 36'o765432_101234) $display("FAIL drop_read_data: got %o want %o", ad, 36'o765432_101234); else pass_cnt++;
    endtask

    task automatic test_random();
        int an, a1, nn, wn, lk, op, exp_ack, exp_we, hold;
        bit r, t, w;
        logic [35:0] ad, d, exp_d;
        logic [63:0] r64;
        logic [19:0] a;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                r64 = {$urandom(), $urandom()};
                a = 20'o2000 + 20'(i);
                run_req(k, mk(0, 0, 1, 0, a), r64[35:0], ws(k) + 3, 2,
                        an, a1, ad, nn, wn, lk);
                mdl[key(k, a)] = r64[35:0];
            end
            for (int i = 0; i < 16; i++) begin
                r64 = {$urandom(), $urandom()};
                d = r64[35:0];
                a = 20'o2000 + 20'($urandom_range(0, 7));
                op = $urandom_range(0, 3);
                r = (op == 0) || (op == 3 && r64[40]);
                t = (op == 1) || (op == 3 && !r64[40]);
                w = (op >= 2);
                exp_ack = ws(k) + 2 + ((op == 3) ? 1 : 0);
                exp_we = w ? 1 : 0;
                exp_d = (r || t) ? mdl[key(k, a)] : 36'o0;
                hold = exp_ack + $urandom_range(0, 2);
                run_req(k, mk(r, t, w, 0, a), d, hold, 2,
                        an, a1, ad, nn, wn, lk);
                if (w) mdl[key(k, a)] = d;
                total++; if (an !== 1 || a1 !== exp_ack) $display("FAIL rand[%0d.%0d]_ack: got n=%0d cycle %0d want 1 %0d", k, i, an, a1, exp_ack); else pass_cnt++;
                total++; if (ad !== exp_d) $display("FAIL rand[%0d.%0d]_data: got %o want %o", k, i, ad, exp_d); else pass_cnt++;
                total++; if (wn !== exp_we || nn !== 0 || lk !== 0) $display("FAIL rand[%0d.%0d]_side: got we=%0d nxm=%0d leak=%0d want %0d 0 0", k, i, wn, nn, lk, exp_we); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int an, a1, nn, wn, lk;
        logic [35:0] ad;
        addr[2] = mk(0, 0, 1, 0, 20'o3100);
        wdat[2] = 36'o5252;
        req[2]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (swe[2] !== 1'b1 || sa[2] !== 20'o3100) $display("FAIL midrst_pre_access: got we=%b addr=%o want 1 3100", swe[2], sa[2]); else pass_cnt++;
        #2 rstN = 1'b0;
        #1;
        total++; if (ack[2] !== 1'b0 || swe[2] !== 1'b0) $display("FAIL midrst_ctl: got ack=%b we=%b want 0 0", ack[2], swe[2]); else pass_cnt++;
        total++; if (dato[2] !== '0 || sa[2] !== '0 || sdo[2] !== '0) $display("FAIL midrst_data: got %o %o %o want 0", dato[2], sa[2], sdo[2]); else pass_cnt++;
        req[2] = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        run_req(2, mk(1, 0, 0, 0, 20'o3000), '0, 6, 2,
                an, a1, ad, nn, wn, lk);
        total++; if (a1 !== 5 || ad !== mdl[key(2, 20'o3000)]) $display("FAIL midrst_after: got cycle %0d data %o want 5 %o", a1, ad, mdl[key(2, 20'o3000)]); else pass_cnt++;
    endtask

    initial begin
        clk  = 1'b0;
        rstN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k]  = 1'b0;
            addr[k] = '0;
            wdat[k] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rstN = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_rmw();
        test_reject();
        test_hold();
        test_drop();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
